// File: rtl/ctrl_pipe_pkg.sv
// Shared opcodes, control-word bit layout and NOP word for the control pipeline.
// Defining CTRL_JALR_EN appends a trailing jalr bit to the control word.
package ctrl_pipe_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IARITH = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

`ifdef CTRL_JALR_EN
    localparam int CTRL_W   = 11;
    localparam int LSB_OFS  = 1;
    localparam int BIT_JALR = 0;
`else
    localparam int CTRL_W   = 10;
    localparam int LSB_OFS  = 0;
`endif

    // Layout {reg_write, mem_to_reg, mem_write, load, store, immd, jal, branch, lui, auipc[, jalr]}
    localparam int BIT_AUIPC      = LSB_OFS + 0;
    localparam int BIT_LUI        = LSB_OFS + 1;
    localparam int BIT_BRANCH     = LSB_OFS + 2;
    localparam int BIT_JAL        = LSB_OFS + 3;
    localparam int BIT_IMMD       = LSB_OFS + 4;
    localparam int BIT_STORE      = LSB_OFS + 5;
    localparam int BIT_LOAD       = LSB_OFS + 6;
    localparam int BIT_MEM_WRITE  = LSB_OFS + 7;
    localparam int BIT_MEM_TO_REG = LSB_OFS + 8;
    localparam int BIT_REG_WRITE  = LSB_OFS + 9;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational opcode decode into a control word plus source-register usage flags.
// JALR decoding is only present when CTRL_JALR_EN is defined.
module ctrl_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       valid,
    output ctrl_word_t ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (valid) begin
            // Unknown opcodes still compare rs1; a spurious stall on garbage is harmless
            uses_rs1 = 1'b1;
            case (opcode_e'(opcode))
                OP_RTYPE: begin
                    ctrl[BIT_REG_WRITE] = 1'b1;
                    uses_rs2            = 1'b1;
                end
                OP_IARITH: begin
                    ctrl[BIT_REG_WRITE] = 1'b1;
                    ctrl[BIT_IMMD]      = 1'b1;
                end
                OP_LOAD: begin
                    ctrl[BIT_REG_WRITE]  = 1'b1;
                    ctrl[BIT_MEM_TO_REG] = 1'b1;
                    ctrl[BIT_LOAD]       = 1'b1;
                    ctrl[BIT_STORE]      = 1'b1;
                    ctrl[BIT_IMMD]       = 1'b1;
                end
                OP_STORE: begin
                    ctrl[BIT_MEM_WRITE] = 1'b1;
                    ctrl[BIT_STORE]     = 1'b1;
                    uses_rs2            = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl[BIT_BRANCH] = 1'b1;
                    uses_rs2         = 1'b1;
                end
                OP_JAL: begin
                    ctrl[BIT_REG_WRITE] = 1'b1;
                    ctrl[BIT_JAL]       = 1'b1;
                    uses_rs1            = 1'b0;
                end
                OP_LUI: begin
                    ctrl[BIT_REG_WRITE] = 1'b1;
                    ctrl[BIT_IMMD]      = 1'b1;
                    ctrl[BIT_LUI]       = 1'b1;
                    uses_rs1            = 1'b0;
                end
                OP_AUIPC: begin
                    ctrl[BIT_REG_WRITE] = 1'b1;
                    ctrl[BIT_IMMD]      = 1'b1;
                    ctrl[BIT_AUIPC]     = 1'b1;
                    uses_rs1            = 1'b0;
                end
                OP_JALR: begin
`ifdef CTRL_JALR_EN
                    ctrl[BIT_REG_WRITE] = 1'b1;
                    ctrl[BIT_IMMD]      = 1'b1;
                    ctrl[BIT_JALR]      = 1'b1;
`else
                    uses_rs1            = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipeline control: decode, ID/EX, EX/MEM, MEM/WB control registers, load-use stall
// and post-redirect squash. CTRL_JALR_EN (in the package) adds JALR decode.
module ctrl_pipe_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int SQUASH_CYCLES = 2
)
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [6:0]        opcode_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              id_valid_i,
    input  logic              redirect_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              squash_o,
    output ctrl_word_t        ex_ctrl_o,
    output ctrl_word_t        mem_ctrl_o,
    output ctrl_word_t        wb_ctrl_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic [REG_AW-1:0] wb_rd_o
);

    // The redirect cycle is itself the first squashed slot, so only the remainder is counted
    localparam logic [1:0] SQUASH_RELOAD = 2'(SQUASH_CYCLES - 1);

    ctrl_word_t        id_ctrl;
    ctrl_word_t        id_ctrl_gated;
    logic              uses_rs1;
    logic              uses_rs2;
    ctrl_word_t        ex_ctrl;
    ctrl_word_t        mem_ctrl;
    ctrl_word_t        wb_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic [1:0]        squash_cnt;
    logic              redirect_pending;
    logic              redirect_eff;
    logic              squash_now;
    logic              hazard;
    logic              stall;

    ctrl_decode u_decode (
        .opcode   (opcode_i),
        .valid    (id_valid_i),
        .ctrl     (id_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    always_comb begin
        redirect_eff = (redirect_i | redirect_pending) & ~hold_i & ~reset_i;
        squash_now   = ~reset_i & (redirect_eff | (squash_cnt != 2'd0));
        hazard       = ex_ctrl[BIT_LOAD] & (ex_rd != '0) & id_valid_i &
                       ((uses_rs1 & (ex_rd == rs1_i)) | (uses_rs2 & (ex_rd == rs2_i)));
        stall        = hazard & ~hold_i & ~squash_now & ~reset_i;
        id_ctrl_gated = id_ctrl;
        if (rd_i == '0) begin
            id_ctrl_gated[BIT_REG_WRITE] = 1'b0;
        end
    end

    // A redirect seen while frozen is parked in redirect_pending until the hold releases
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex_ctrl          <= CTRL_NOP;
            mem_ctrl         <= CTRL_NOP;
            wb_ctrl          <= CTRL_NOP;
            ex_rd            <= '0;
            mem_rd           <= '0;
            wb_rd            <= '0;
            squash_cnt       <= 2'd0;
            redirect_pending <= 1'b0;
        end else if (hold_i) begin
            if (redirect_i) begin
                redirect_pending <= 1'b1;
            end
        end else begin
            redirect_pending <= 1'b0;
            wb_ctrl          <= mem_ctrl;
            wb_rd            <= mem_rd;
            mem_ctrl         <= ex_ctrl;
            mem_rd           <= ex_rd;
            if (squash_now | stall) begin
                ex_ctrl <= CTRL_NOP;
                ex_rd   <= '0;
            end else begin
                ex_ctrl <= id_ctrl_gated;
                ex_rd   <= id_valid_i ? rd_i : '0;
            end
            if (redirect_eff) begin
                squash_cnt <= SQUASH_RELOAD;
            end else if (squash_cnt != 2'd0) begin
                squash_cnt <= squash_cnt - 2'd1;
            end
        end
    end

    assign stall_o    = stall;
    assign squash_o   = squash_now;
    assign ex_ctrl_o  = ex_ctrl;
    assign mem_ctrl_o = mem_ctrl;
    assign wb_ctrl_o  = wb_ctrl;
    assign ex_rd_o    = ex_rd;
    assign mem_rd_o   = mem_rd;
    assign wb_rd_o    = wb_rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: fixed vector table, directed corner sequences and random
// traffic against a slot-level reference model. Honours CTRL_JALR_EN.
module tb_ctrl_pipe_unit;

`ifdef CTRL_JALR_EN
    localparam int CW = 11;
`else
    localparam int CW = 10;
`endif
    localparam int SQ = 2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [6:0]    opcode_i;
    logic [4:0]    rs1_i, rs2_i, rd_i;
    logic          id_valid_i, redirect_i, hold_i;
    logic          stall_o, squash_o;
    logic [CW-1:0] ex_ctrl_o, mem_ctrl_o, wb_ctrl_o;
    logic [4:0]    ex_rd_o, mem_rd_o, wb_rd_o;

    ctrl_pipe_unit #(.REG_AW(5), .SQUASH_CYCLES(SQ)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .opcode_i   (opcode_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .id_valid_i (id_valid_i),
        .redirect_i (redirect_i),
        .hold_i     (hold_i),
        .stall_o    (stall_o),
        .squash_o   (squash_o),
        .ex_ctrl_o  (ex_ctrl_o),
        .mem_ctrl_o (mem_ctrl_o),
        .wb_ctrl_o  (wb_ctrl_o),
        .ex_rd_o    (ex_rd_o),
        .mem_rd_o   (mem_rd_o),
        .wb_rd_o    (wb_rd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       valid;
        logic       redirect;
        logic       hold;
    } stim_t;

    typedef struct packed {
        stim_t         s;
        logic          exp_stall;
        logic          exp_squash;
        logic [CW-1:0] exp_ex_ctrl;
        logic [4:0]    exp_ex_rd;
    } vec_t;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [4:0]    rd;
        logic          is_load;
    } slot_t;

    int    errors = 0;
    int    checks = 0;
    stim_t cur = '0;
    slot_t pipe [3];
    int    squash_left;
    bit    pend;

    function automatic logic [CW-1:0] w(input logic [9:0] b);
`ifdef CTRL_JALR_EN
        return {b, 1'b0};
`else
        return b;
`endif
    endfunction

    function automatic stim_t mk(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd, input logic v, input logic rdr, input logic h);
        stim_t s;
        s.opcode = op; s.rs1 = r1; s.rs2 = r2; s.rd = rd;
        s.valid = v; s.redirect = rdr; s.hold = h;
        return s;
    endfunction

    // Reference decode straight from the opcode table
    function automatic logic [CW-1:0] spec_word(input logic [6:0] op, input logic valid);
        if (!valid) return '0;
        case (op)
            OP_R:      return w(10'b1000000000);
            OP_IARITH: return w(10'b1000010000);
            OP_LOAD:   return w(10'b1101110000);
            OP_STORE:  return w(10'b0010100000);
            OP_BRANCH: return w(10'b0000000100);
            OP_JAL:    return w(10'b1000001000);
            OP_LUI:    return w(10'b1000010010);
            OP_AUIPC:  return w(10'b1000010001);
`ifdef CTRL_JALR_EN
            OP_JALR:   return {10'b1000010000, 1'b1};
`endif
            default:   return '0;
        endcase
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        if (op == OP_JAL || op == OP_LUI || op == OP_AUIPC) return 1'b0;
`ifndef CTRL_JALR_EN
        if (op == OP_JALR) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        squash_left = 0;
        pend = 1'b0;
    endtask

    task automatic model_comb(output bit e_stall, output bit e_squash);
        bit redir;
        bit haz;
        redir = (cur.redirect || pend) && !cur.hold;
        e_squash = redir || (squash_left > 0);
        haz = pipe[0].is_load && (pipe[0].rd != 0) && cur.valid &&
              ((reads_rs1(cur.opcode) && cur.rs1 == pipe[0].rd) ||
               (reads_rs2(cur.opcode) && cur.rs2 == pipe[0].rd));
        e_stall = haz && !cur.hold && !e_squash;
        if (reset_i) begin
            e_stall = 1'b0;
            e_squash = 1'b0;
        end
    endtask

    // One clock edge of the reference: slots shift, ID slot fills or gets a bubble
    task automatic model_step();
        bit st, sq, redir;
        slot_t nxt;
        if (reset_i) begin
            model_reset();
            return;
        end
        model_comb(st, sq);
        if (cur.hold) begin
            if (cur.redirect) pend = 1'b1;
            return;
        end
        redir = cur.redirect || pend;
        pend = 1'b0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        nxt = '0;
        if (!(sq || st)) begin
            nxt.ctrl = spec_word(cur.opcode, cur.valid);
            if (cur.rd == 0) nxt.ctrl[CW-1] = 1'b0;
            nxt.rd = cur.valid ? cur.rd : 5'd0;
            nxt.is_load = cur.valid && (cur.opcode == OP_LOAD);
        end
        pipe[0] = nxt;
        if (redir) squash_left = SQ - 1;
        else if (squash_left > 0) squash_left--;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        bit e_stall, e_squash;
        model_comb(e_stall, e_squash);
        check_val("stall_o",    32'(stall_o),    32'(e_stall));
        check_val("squash_o",   32'(squash_o),   32'(e_squash));
        check_val("ex_ctrl_o",  32'(ex_ctrl_o),  32'(pipe[0].ctrl));
        check_val("mem_ctrl_o", 32'(mem_ctrl_o), 32'(pipe[1].ctrl));
        check_val("wb_ctrl_o",  32'(wb_ctrl_o),  32'(pipe[2].ctrl));
        check_val("ex_rd_o",    32'(ex_rd_o),    32'(pipe[0].rd));
        check_val("mem_rd_o",   32'(mem_rd_o),   32'(pipe[1].rd));
        check_val("wb_rd_o",    32'(wb_rd_o),    32'(pipe[2].rd));
    endtask

    task automatic apply_stimulus(input stim_t s);
        @(negedge clk_i);
        cur = s;
        opcode_i = s.opcode; rs1_i = s.rs1; rs2_i = s.rs2; rd_i = s.rd;
        id_valid_i = s.valid; redirect_i = s.redirect; hold_i = s.hold;
        #2;
    endtask

    task automatic finish_cycle();
        @(posedge clk_i);
        model_step();
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        case ($urandom_range(0, 9))
            0: s.opcode = OP_LOAD;
            1: s.opcode = OP_IARITH;
            2: s.opcode = OP_AUIPC;
            3: s.opcode = OP_STORE;
            4: s.opcode = OP_R;
            5: s.opcode = OP_LUI;
            6: s.opcode = OP_BRANCH;
            7: s.opcode = OP_JALR;
            8: s.opcode = OP_JAL;
            default: s.opcode = 7'($urandom);
        endcase
        s.rs1 = 5'($urandom_range(0, 3));
        s.rs2 = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.valid = ($urandom_range(0, 99) < 85);
        s.redirect = ($urandom_range(0, 99) < 8);
        s.hold = ($urandom_range(0, 99) < 12);
        return s;
    endfunction

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{mk(OP_LOAD,   1, 0,  5, 1, 0, 0), 1'b0, 1'b0, '0, 5'd0};
        tbl[1]  = '{mk(OP_R,      5, 2,  6, 1, 0, 0), 1'b1, 1'b0, w(10'b1101110000), 5'd5};
        tbl[2]  = '{mk(OP_R,      5, 2,  6, 1, 0, 0), 1'b0, 1'b0, '0, 5'd0};
        tbl[3]  = '{mk(OP_IARITH, 6, 0,  7, 1, 0, 0), 1'b0, 1'b0, w(10'b1000000000), 5'd6};
        tbl[4]  = '{mk(OP_LOAD,   3, 0,  0, 1, 0, 0), 1'b0, 1'b0, w(10'b1000010000), 5'd7};
        tbl[5]  = '{mk(OP_R,      0, 0,  8, 1, 0, 0), 1'b0, 1'b0, w(10'b0101110000), 5'd0};
        tbl[6]  = '{mk(OP_LOAD,   1, 0,  9, 1, 0, 0), 1'b0, 1'b0, w(10'b1000000000), 5'd8};
        tbl[7]  = '{mk(OP_STORE,  1, 9,  0, 1, 1, 0), 1'b0, 1'b1, w(10'b1101110000), 5'd9};
        tbl[8]  = '{mk(OP_R,      1, 2, 10, 1, 0, 0), 1'b0, 1'b1, '0, 5'd0};
        tbl[9]  = '{mk(OP_R,      1, 2, 11, 1, 0, 0), 1'b0, 1'b0, '0, 5'd0};
        tbl[10] = '{mk(7'd0,      0, 0,  0, 0, 0, 0), 1'b0, 1'b0, w(10'b1000000000), 5'd11};
        tbl[11] = '{mk(7'd0,      0, 0,  0, 0, 0, 0), 1'b0, 1'b0, '0, 5'd0};

        reset_i = 1'b1;
        opcode_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        id_valid_i = 1'b0; redirect_i = 1'b0; hold_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        check_output();
        reset_i = 1'b0;

        // Vector table: load-use, rd=0 load, redirect with hazard, squash window
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(tbl[i].s);
            check_output();
            check_val($sformatf("tbl%0d_stall", i),   32'(stall_o),   32'(tbl[i].exp_stall));
            check_val($sformatf("tbl%0d_squash", i),  32'(squash_o),  32'(tbl[i].exp_squash));
            check_val($sformatf("tbl%0d_ex_ctrl", i), 32'(ex_ctrl_o), 32'(tbl[i].exp_ex_ctrl));
            check_val($sformatf("tbl%0d_ex_rd", i),   32'(ex_rd_o),   32'(tbl[i].exp_ex_rd));
            finish_cycle();
        end

        // Hold for three cycles in the middle of a squash window
        apply_stimulus(mk(OP_R, 1, 2, 12, 1, 0, 0)); check_output(); finish_cycle();
        apply_stimulus(mk(OP_IARITH, 1, 0, 13, 1, 1, 0)); check_output();
        check_val("hold_redirect_squash", 32'(squash_o), 32'd1);
        finish_cycle();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(mk(OP_R, 1, 2, 14, 1, 0, 1)); check_output();
            check_val("hold_squash", 32'(squash_o), 32'd1);
            check_val("hold_stall", 32'(stall_o), 32'd0);
            check_val("hold_ex_ctrl", 32'(ex_ctrl_o), 32'd0);
            check_val("hold_mem_ctrl", 32'(mem_ctrl_o), 32'(w(10'b1000000000)));
            check_val("hold_mem_rd", 32'(mem_rd_o), 32'd12);
            finish_cycle();
        end
        apply_stimulus(mk(OP_R, 1, 2, 14, 1, 0, 0)); check_output();
        check_val("resume_squash", 32'(squash_o), 32'd1);
        finish_cycle();
        apply_stimulus(mk(OP_R, 1, 2, 15, 1, 0, 0)); check_output();
        check_val("resume_done_squash", 32'(squash_o), 32'd0);
        check_val("resume_mem_ctrl", 32'(mem_ctrl_o), 32'd0);
        finish_cycle();
        apply_stimulus(mk(7'd0, 0, 0, 0, 0, 0, 0)); check_output();
        check_val("resume_ex_rd", 32'(ex_rd_o), 32'd15);
        check_val("resume_ex_ctrl", 32'(ex_ctrl_o), 32'(w(10'b1000000000)));
        finish_cycle();

        // Asynchronous reset in the middle of a redirect and a pending load-use
        apply_stimulus(mk(OP_LOAD, 1, 0, 5, 1, 0, 0)); check_output(); finish_cycle();
        apply_stimulus(mk(OP_R, 5, 2, 6, 1, 1, 0)); check_output();
        check_val("redir_hazard_stall", 32'(stall_o), 32'd0);
        check_val("redir_hazard_squash", 32'(squash_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check_val("async_rst_stall", 32'(stall_o), 32'd0);
        check_val("async_rst_squash", 32'(squash_o), 32'd0);
        check_val("async_rst_ex_ctrl", 32'(ex_ctrl_o), 32'd0);
        check_val("async_rst_ex_rd", 32'(ex_rd_o), 32'd0);
        check_val("async_rst_mem_ctrl", 32'(mem_ctrl_o), 32'd0);
        check_val("async_rst_mem_rd", 32'(mem_rd_o), 32'd0);
        check_val("async_rst_wb_ctrl", 32'(wb_ctrl_o), 32'd0);
        check_val("async_rst_wb_rd", 32'(wb_rd_o), 32'd0);
        model_reset();
        finish_cycle();
        apply_stimulus(mk(OP_R, 1, 2, 6, 1, 1, 1)); check_output();
        check_val("in_rst_squash", 32'(squash_o), 32'd0);
        finish_cycle();
        #1 reset_i = 1'b0;
        apply_stimulus(mk(OP_R, 1, 2, 16, 1, 0, 0)); check_output();
        check_val("post_rst_squash", 32'(squash_o), 32'd0);
        finish_cycle();
        apply_stimulus(mk(7'd0, 0, 0, 0, 0, 0, 0)); check_output();
        check_val("post_rst_ex_rd", 32'(ex_rd_o), 32'd16);
        check_val("post_rst_ex_ctrl", 32'(ex_ctrl_o), 32'(w(10'b1000000000)));
        finish_cycle();

        // JALR decode
        apply_stimulus(mk(OP_JALR, 2, 0, 17, 1, 0, 0)); check_output(); finish_cycle();
        apply_stimulus(mk(7'd0, 0, 0, 0, 0, 0, 0)); check_output();
`ifdef CTRL_JALR_EN
        check_val("jalr_bit", 32'(ex_ctrl_o[0]), 32'd1);
        check_val("jalr_rd", 32'(ex_rd_o), 32'd17);
`else
        check_val("jalr_bubble", 32'(ex_ctrl_o), 32'd0);
`endif
        finish_cycle();

        for (int i = 0; i < 600; i++) begin
            apply_stimulus(rand_stim());
            check_output();
            finish_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
